// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encoding, drain default and load-use decode for hazard_ctrl
// Contents: hz_state_e (WARMUP/RUN/DRAIN/HALTED), DRAIN_CYCLES_DEFAULT, load_use_hit()
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } hz_state_e;

  localparam int DRAIN_CYCLES_DEFAULT = 4;

  // A load in EX whose destination is read by the instruction in ID.
  // Register 0 never carries a real dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       uses_rt
  );
    return mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter used for stall/flush statistics
// Ports: clk, reset (async active-low), inc (count one event), count (holds at all-ones)
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch/jump flush, drain-and-halt
// Inputs : clk, reset (async active-low), id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
//          branch_taken, jump, halt_req
// Outputs: pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, halt_ack, state,
//          stall_cnt, flush_cnt
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rt,
  input  logic                 branch_taken,
  input  logic                 jump,
  input  logic                 halt_req,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 halt_ack,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  hz_state_e         state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;

  assign load_use = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
  assign state    = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WARMUP;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halt_ack     = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    unique case (state_q)
      ST_WARMUP: begin
        // Fill every stage with bubbles before the first real fetch.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
        end else if (jump) begin
          if_id_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end

      ST_DRAIN: begin
        // Fetch is frozen; IF/ID keeps loading bubbles so older work drains out.
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        if (branch_taken) begin
          // A redirect refills the pipe with the target path, so draining restarts.
          pc_en        = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
          drain_d      = '0;
        end else begin
          if (jump) begin
            pc_en     = 1'b1;
            flush_inc = 1'b1;
            drain_d   = drain_q + DW'(1);
          end else if (load_use) begin
            // Stalled cycle: nothing left the pipe, so the drain count holds.
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            drain_d = drain_q + DW'(1);
          end
          if (drain_d == DW'(DRAIN_CYCLES)) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        halt_ack = 1'b1;
        if (!halt_req) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_WARMUP;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-level behavioural model
module tb_hazard_ctrl;

  localparam int CW  = 5;
  localparam int DC  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, branch_taken, jump, halt_req;
  logic          pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, halt_ack;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [5:0]    ctrl;

  int checks = 0;
  int errors = 0;

  int m_mode  = 0;
  int m_drain = 0;
  int m_stall = 0;
  int m_flush = 0;

  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, halt_ack};

  hazard_ctrl #(.CNT_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .halt_ack     (halt_ack),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    ex_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    ex_mem_read  = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    halt_req     = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected outputs from the current mode and inputs,
  // then advance the mode exactly as the rules describe.
  always @(negedge clk) begin
    logic       lu;
    logic [5:0] exp_ctrl;
    if (!reset) begin
      m_mode  = 0;
      m_drain = 0;
      m_stall = 0;
      m_flush = 0;
    end
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // bit order: pc_en if_id_en if_id_flush id_ex_flush ex_mem_flush halt_ack
    case (m_mode)
      0:       exp_ctrl = 6'b001110;
      1:       exp_ctrl = branch_taken ? 6'b111110 : jump ? 6'b111000 :
                          lu ? 6'b000100 : 6'b110000;
      2:       exp_ctrl = branch_taken ? 6'b111110 : jump ? 6'b111000 :
                          lu ? 6'b001100 : 6'b011000;
      default: exp_ctrl = 6'b000001;
    endcase
    check("model_state_ctrl", {56'd0, state, ctrl}, {56'd0, 2'(m_mode), exp_ctrl});
    check("model_counters", {54'd0, stall_cnt, flush_cnt}, {54'd0, CW'(m_stall), CW'(m_flush)});

    if (reset) begin
      if (m_mode == 1 || m_mode == 2) begin
        if (branch_taken || jump) begin
          if (m_flush < MAX) m_flush++;
        end else if (lu) begin
          if (m_stall < MAX) m_stall++;
        end
      end
      case (m_mode)
        0: m_mode = 1;
        1: if (!branch_taken && !jump && !lu && halt_req) begin
             m_mode  = 2;
             m_drain = 0;
           end
        2: if (branch_taken) begin
             m_drain = 0;
           end else if (jump || !lu) begin
             m_drain++;
             if (m_drain == DC) m_mode = 3;
           end
        default: if (!halt_req) m_mode = 1;
      endcase
    end
  end

  initial begin
    reset = 1'b1;
    set_idle();
    #1 reset = 1'b0;

    mid();
    check("reset_state", 64'(state), 64'd0);
    check("reset_ctrl", 64'(ctrl), 64'b001110);
    check("reset_counters", {54'd0, stall_cnt, flush_cnt}, 64'd0);
    edge_();
    edge_();
    reset = 1'b1;
    mid();
    check("warmup_one_cycle", 64'(state), 64'd0);
    edge_();
    mid();
    check("run_after_warmup", 64'(state), 64'd1);
    edge_();

    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    mid();
    check("load_use_stall_ctrl", 64'(ctrl), 64'b000100);
    edge_();
    check("load_use_stall_cnt", 64'(stall_cnt), 64'd1);

    ex_rt = 5'd0; id_rs = 5'd0;
    mid();
    check("r0_no_stall_ctrl", 64'(ctrl), 64'b110000);
    edge_();
    check("r0_no_stall_cnt", 64'(stall_cnt), 64'd1);

    set_idle();
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
    id_uses_rt = 1'b1; id_rs = 5'd9;
    mid();
    check("branch_over_load_use_ctrl", 64'(ctrl), 64'b111110);
    edge_();
    check("branch_counters", {54'd0, stall_cnt, flush_cnt}, {54'd0, 5'd1, 5'd1});

    set_idle();
    halt_req = 1'b1;
    mid();
    check("halt_accept_in_run", 64'(state), 64'd1);
    edge_();
    for (int i = 0; i < DC; i++) begin
      mid();
      check("drain_cycle_state", 64'(state), 64'd2);
      edge_();
    end
    mid();
    check("halted_with_ack", {61'd0, state, halt_ack}, {61'd0, 2'd3, 1'b1});
    edge_();
    halt_req = 1'b0;
    mid();
    check("halted_until_release", 64'(state), 64'd3);
    edge_();
    mid();
    check("run_after_halt", {61'd0, state, halt_ack}, {61'd0, 2'd1, 1'b0});
    edge_();

    halt_req = 1'b1;
    edge_();
    mid();
    check("drain_first_cycle", 64'(state), 64'd2);
    edge_();
    reset = 1'b0;
    #1;
    check("reset_mid_drain_state", 64'(state), 64'd0);
    check("reset_mid_drain_counters", {54'd0, stall_cnt, flush_cnt}, 64'd0);
    check("reset_mid_drain_ctrl", 64'(ctrl), 64'b001110);
    mid();
    edge_();
    reset = 1'b1;
    halt_req = 1'b0;
    mid();
    check("warmup_after_drain_reset", 64'(state), 64'd0);
    edge_();
    mid();
    check("run_after_drain_reset", 64'(state), 64'd1);
    edge_();

    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    repeat (MAX - 1) edge_();
    check("stall_cnt_max_minus_1", 64'(stall_cnt), 64'(MAX - 1));
    repeat (3) edge_();
    check("stall_cnt_saturated", 64'(stall_cnt), 64'(MAX));
    set_idle();
    edge_();

    for (int c = 0; c < 3000; c++) begin
      if (!reset) begin
        if ($urandom_range(0, 1) == 0) reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
      end
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_rt        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      edge_();
    end

    mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
